// File: rtl/fir_alu_pkg.sv
// Shared encodings for the FIR MAC datapath.
// Holds operation modes and controller FSM states.
package fir_alu_pkg;

  typedef enum logic [1:0] {
    MODE_RSV = 2'b00,
    MODE_ADD = 2'b01,
    MODE_MUL = 2'b10,
    MODE_MAC = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/fir_mul_stage.sv
// Stage-1 operator: registers a+b (ADD) or a*b (MUL/MAC).
// Ports: clk, reset, en, mode, a, b -> p (2*DW), vld.
module fir_mul_stage
  import fir_alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  mode_e         mode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [2*DW-1:0] p,
  output logic          vld
);

  logic [2*DW-1:0] p_d, p_q;
  logic            vld_d, vld_q;
  logic [2*DW-1:0] a_x, b_x;

  assign a_x = {{DW{1'b0}}, a};
  assign b_x = {{DW{1'b0}}, b};

  always_comb begin
    p_d   = p_q;
    vld_d = en;
    if (en) begin
      if (mode == MODE_ADD) p_d = a_x + b_x;
      else                  p_d = a_x * b_x;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      vld_q <= vld_d;
    end
  end

  assign p   = p_q;
  assign vld = vld_q;

endmodule

// File: rtl/fir_mac_unit.sv
// FIR MAC unit: ADD/MUL single op or TAPS-long MAC with handshakes.
// Ports: start/mode, a/b/in_valid/in_ready, result/zout/cout/out_valid/out_ready, busy.
module fir_mac_unit
  import fir_alu_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 20,
  parameter int TAPS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] result,
  output logic             zout,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = (TAPS < 2) ? 1 : $clog2(TAPS + 1);
  localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

  state_e           state_d, state_q;
  mode_e            mode_d, mode_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [ACC_W-1:0] res_d, res_q;
  logic             cout_d, cout_q;

  logic            accept;
  logic [2*DW-1:0] s1_p;
  logic            s1_vld;
  logic [ACC_W:0]  sum;

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = in_valid & in_ready;

  fir_mul_stage #(.DW(DW)) u_s1 (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .mode  (mode_q),
    .a     (a),
    .b     (b),
    .p     (s1_p),
    .vld   (s1_vld)
  );

  // Extra top bit captures the carry out of the accumulator.
  assign sum = {1'b0, acc_q}
             + {{(ACC_W + 1 - 2*DW){1'b0}}, s1_p};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cout_d  = cout_q;

    if (s1_vld) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) cout_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && (mode != 2'b00)) begin
          mode_d  = mode_e'(mode);
          acc_d   = '0;
          cnt_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (mode_q != MODE_MAC || cnt_q == LAST)
            state_d = ST_DRAIN;
        end
      end
      // Wait for the last product to land in the accumulator.
      ST_DRAIN: begin
        if (!s1_vld) begin
          res_d   = acc_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_RSV;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign zout   = out_valid & (res_q == '0);

endmodule
